// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier operand dispatcher: default
// operand width, default op_done watchdog limit and the sequencer states.
package mul_pkg;

    localparam int unsigned MUL_WIDTH   = 64;
    localparam int unsigned MUL_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        OUTPUT  = 2'd3
    } mul_state_t;

endpackage

// File: rtl/mul_operand_fifo.sv
// Operand-pair FIFO: DEPTH entries of DATA_W bits, head presented
// combinationally, occupancy exported as a registered count.
module mul_operand_fifo
    import mul_pkg::*;
#(
    parameter int unsigned DATA_W = 2 * MUL_WIDTH,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^AW).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/mul_operand_dispatcher.sv
// Front-end sequencer for the radix-4 multiplier: queues operand pairs,
// issues one at a time with a level start, captures the product, pulses
// clear and presents the product on a valid/ready port.
// Optional op_done watchdog enabled by defining MUL_TIMEOUT_EN.
module mul_operand_dispatcher
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH          = MUL_WIDTH,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = MUL_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_multiplicand,
    input  logic [WIDTH-1:0]              in_multiplier,
    output logic [WIDTH-1:0]              mul_multiplicand,
    output logic [WIDTH-1:0]              mul_multiplier,
    output logic                          mul_op_start,
    output logic                          mul_op_clear,
    input  logic                          mul_op_done,
    input  logic [2*WIDTH-1:0]            mul_result,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2*WIDTH-1:0]            out_result,
    output logic                          out_error,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    mul_state_t        r_state;
    mul_state_t        w_next;
    logic              r_alive;
    logic [2*WIDTH-1:0] w_head;
    logic              w_have;
    logic              w_push;
    logic              w_pop;
    logic              w_timeout;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [2*WIDTH-1:0] r_result;

    // in_ready looks only at the registered count, so a push can never
    // land on a full FIFO even if a pop happens in the same cycle.
    assign w_have   = (fifo_count != '0);
    assign in_ready = r_alive && (fifo_count != FULL_CNT);
    assign w_push   = in_valid && in_ready;
    assign w_pop    = w_have && ((r_state == IDLE) || ((r_state == OUTPUT) && out_ready));

    mul_operand_fifo #(
        .DATA_W (2 * WIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({in_multiplicand, in_multiplier}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (fifo_count)
    );

`ifdef MUL_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_timer;
    logic          r_error;

    // Counts cycles spent in ISSUE; cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (r_state == ISSUE) begin
            r_timer <= r_timer + 1'b1;
        end else begin
            r_timer <= '0;
        end
    end

    // A real op_done in the final allowed cycle wins over the timeout.
    assign w_timeout = (r_state == ISSUE) && !mul_op_done
                       && (r_timer == TW'(TIMEOUT_CYCLES - 1));

    // Error flag describes the product currently held in out_result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if ((r_state == ISSUE) && mul_op_done) begin
            r_error <= 1'b0;
        end else if (w_timeout) begin
            r_error <= 1'b1;
        end
    end

    assign out_error = r_error && out_valid;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign w_timeout        = 1'b0;
    assign out_error        = 1'b0;
`endif

    // Holds in_ready low until the first clock after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection; OUTPUT chains straight into ISSUE when work is queued.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_have) w_next = ISSUE;
            ISSUE:   if (mul_op_done || w_timeout) w_next = CAPTURE;
            CAPTURE: w_next = OUTPUT;
            OUTPUT:  if (out_ready) w_next = w_have ? ISSUE : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State-decoded control outputs.
    always_comb begin
        mul_op_start = 1'b0;
        mul_op_clear = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ISSUE:   mul_op_start = 1'b1;
            CAPTURE: mul_op_clear = 1'b1;
            OUTPUT:  out_valid    = 1'b1;
            default: ;
        endcase
    end

    // Operand registers load only on pop, so they stay fixed through ISSUE;
    // the product is latched on the edge that leaves ISSUE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else begin
            if (w_pop) begin
                {r_a, r_b} <= w_head;
            end
            if ((r_state == ISSUE) && mul_op_done) begin
                r_result <= mul_result;
            end else if (w_timeout) begin
                r_result <= '0;
            end
        end
    end

    assign mul_multiplicand = r_a;
    assign mul_multiplier   = r_b;
    assign out_result       = r_result;

endmodule

// File: tb/tb_mul_operand_dispatcher.sv
// Self-checking bench for mul_operand_dispatcher with a behavioural
// multiplier and a queue-based reference model.
module tb_mul_operand_dispatcher;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [63:0]  in_multiplicand = '0;
    logic [63:0]  in_multiplier = '0;
    logic [63:0]  mul_multiplicand;
    logic [63:0]  mul_multiplier;
    logic         mul_op_start;
    logic         mul_op_clear;
    logic         mul_op_done = 1'b0;
    logic [127:0] mul_result = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_result;
    logic         out_error;
    logic [2:0]   fifo_count;

    mul_operand_dispatcher #(
        .WIDTH          (64),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_multiplicand  (in_multiplicand),
        .in_multiplier    (in_multiplier),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_op_start     (mul_op_start),
        .mul_op_clear     (mul_op_clear),
        .mul_op_done      (mul_op_done),
        .mul_result       (mul_result),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_result       (out_result),
        .out_error        (out_error),
        .fifo_count       (fifo_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] sprod(input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] ea;
        logic signed [127:0] eb;
        ea = {{64{a[63]}}, a};
        eb = {{64{b[63]}}, b};
        return ea * eb;
    endfunction

    // Environment controls
    bit stall = 1'b0;
    bit spur_req = 1'b0;
    bit rand_rdy = 1'b0;
    bit fixed_rdy = 1'b1;

    // Behavioural multiplier: random latency, garbage on mul_result when not done.
    bit m_busy = 1'b0;
    bit m_fired = 1'b0;
    int m_rem = 0;
    always begin
        @(posedge clk);
        #1;
        mul_op_done = 1'b0;
        mul_result  = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (reset) begin
            m_busy  = 1'b0;
            m_fired = 1'b0;
        end else if (mul_op_start) begin
            if (!m_busy) begin
                m_busy  = 1'b1;
                m_fired = 1'b0;
                m_rem   = int'($urandom_range(0, 3));
            end else if (m_rem != 0) begin
                m_rem--;
            end
            if (m_rem == 0 && !stall && !m_fired) begin
                mul_op_done = 1'b1;
                mul_result  = sprod(mul_multiplicand, mul_multiplier);
                m_fired     = 1'b1;
            end
        end else begin
            m_busy = 1'b0;
            if (spur_req) mul_op_done = 1'b1;
        end
    end

    // Consumer readiness
    always begin
        @(posedge clk);
        #1;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : fixed_rdy;
    end

    // in_ready may only rise once a clock edge has seen reset low
    logic alive_m;
    always @(posedge clk or posedge reset) begin
        if (reset) alive_m <= 1'b0;
        else       alive_m <= 1'b1;
    end

    // Reference model state
    logic [127:0] opq[$];
    logic [127:0] expq[$];
    bit           doneq[$];
    int           pushes = 0;
    int           issues = 0;
    int           cyc = 0;
    int           done_cyc = 0;
    int           start_len = 0;
    int           done_n = 0;
    int           clears = 0;
    bit           have_done = 1'b0;
    bit           cur_done = 1'b0;
    logic         p_start = 1'b0;
    logic         p_ov = 1'b0;
    logic         p_or = 1'b0;
    logic         p_clear = 1'b0;
    logic [63:0]  p_a = '0;
    logic [63:0]  p_b = '0;
    logic [127:0] p_res = '0;
    logic [127:0] last_res = '0;
    logic         last_err = 1'b0;
    logic [127:0] res_log [256];

    // Per-cycle compare against the model
    always @(negedge clk) begin
        logic [127:0] pr;
        logic [127:0] e;
        logic [127:0] e_res;
        logic         e_err;
        bit           d;
        cyc++;
        if (reset) begin
            opq.delete();
            expq.delete();
            doneq.delete();
            pushes    = 0;
            issues    = 0;
            have_done = 1'b0;
            cur_done  = 1'b0;
            p_start   = 1'b0;
            p_ov      = 1'b0;
            p_or      = 1'b0;
            p_clear   = 1'b0;
        end else begin
            if (mul_op_start && !p_start) begin
                issues++;
                start_len = 0;
                cur_done  = 1'b0;
                chk("issue_has_operands", 128'(opq.size() != 0), 128'd1);
                if (opq.size() != 0) begin
                    pr = opq.pop_front();
                    chk("issue_multiplicand", 128'(mul_multiplicand), 128'(pr[127:64]));
                    chk("issue_multiplier", 128'(mul_multiplier), 128'(pr[63:0]));
                    expq.push_back(sprod(pr[127:64], pr[63:0]));
                end
            end
            if (mul_op_start && p_start) begin
                chk("operand_a_stable", 128'(mul_multiplicand), 128'(p_a));
                chk("operand_b_stable", 128'(mul_multiplier), 128'(p_b));
            end
            if (mul_op_start) start_len++;
            if (mul_op_start && mul_op_done) begin
                cur_done  = 1'b1;
                have_done = 1'b1;
                done_cyc  = cyc;
            end
            if (p_start && !mul_op_start) begin
                doneq.push_back(cur_done);
`ifdef MUL_TIMEOUT_EN
                if (!cur_done) chk("timeout_cycles", 128'(start_len), 128'd64);
`else
                chk("issue_ended_by_done", 128'(cur_done), 128'd1);
`endif
            end
            chk("fifo_count", 128'(fifo_count), 128'(pushes - issues));
            chk("in_ready", 128'(in_ready), 128'(alive_m && (pushes - issues) < 4));
            chk("clear_single_cycle", 128'(mul_op_clear && p_clear), 128'd0);
            if (mul_op_clear) clears++;
            if (out_valid && !p_ov) begin
                if (have_done) chk("done_to_valid_latency", 128'(cyc - done_cyc), 128'd2);
                have_done = 1'b0;
            end
            if (p_ov && !p_or) begin
                chk("valid_held", 128'(out_valid), 128'd1);
                chk("result_held", out_result, p_res);
            end
            if (out_valid && out_ready) begin
                chk("result_expected", 128'(expq.size() != 0 && doneq.size() != 0), 128'd1);
                if (expq.size() != 0 && doneq.size() != 0) begin
                    e = expq.pop_front();
                    d = doneq.pop_front();
`ifdef MUL_TIMEOUT_EN
                    e_res = d ? e : '0;
                    e_err = !d;
`else
                    e_res = e;
                    e_err = 1'b0;
`endif
                    chk("out_result", out_result, e_res);
                    chk("out_error", 128'(out_error), 128'(e_err));
                end
                res_log[done_n[7:0]] = out_result;
                last_res = out_result;
                last_err = out_error;
                done_n++;
            end
            if (in_valid && in_ready) begin
                opq.push_back({in_multiplicand, in_multiplier});
                pushes++;
            end
            p_start = mul_op_start;
            p_ov    = out_valid;
            p_or    = out_ready;
            p_clear = mul_op_clear;
            p_a     = mul_multiplicand;
            p_b     = mul_multiplier;
            p_res   = out_result;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] a, input logic [63:0] b);
        bit acc;
        acc = 1'b0;
        in_valid        = 1'b1;
        in_multiplicand = a;
        in_multiplier   = b;
        for (int i = 0; i < 500 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        chk("push_accepted", 128'(acc), 128'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, input int budget);
        for (int i = 0; i < budget && done_n < n; i++) tick();
        chk("results_arrived", 128'(done_n >= n), 128'd1);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'h7FFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return '1;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int c0;
        bit seen;

        // Reset state
        repeat (3) tick();
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_start", 128'(mul_op_start), 128'd0);
        chk("rst_clear", 128'(mul_op_clear), 128'd0);
        chk("rst_fifo_count", 128'(fifo_count), 128'd0);
        chk("rst_out_result", out_result, 128'd0);
        reset = 1'b0;
        tick();
        chk("in_ready_after_release", 128'(in_ready), 128'd1);

        // 1: 5 * -20
        base = done_n;
        c0   = clears;
        push(64'd5, -64'sd20);
        wait_results(base + 1, 100);
        repeat (3) tick();
        chk("t1_product", res_log[base[7:0]], 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF9C);
        chk("t1_clear_pulses", 128'(clears - c0), 128'd1);

        // 2: fill the FIFO behind a stalled operation
        base  = done_n;
        stall = 1'b1;
        push(64'd9, 64'd9);
        push(64'd5, 64'd4);
        push(64'd3, 64'd3);
        push('1, '1);
        push(64'd0, 64'd7);
        chk("t2_full_count", 128'(fifo_count), 128'd4);
        chk("t2_full_not_ready", 128'(in_ready), 128'd0);
        in_valid        = 1'b1;
        in_multiplicand = 64'd8;
        in_multiplier   = 64'd8;
        repeat (3) tick();
        in_valid = 1'b0;
        stall    = 1'b0;
        wait_results(base + 5, 200);
        chk("t2_r0", res_log[(base + 0) & 255], 128'd81);
        chk("t2_r1", res_log[(base + 1) & 255], 128'd20);
        chk("t2_r2", res_log[(base + 2) & 255], 128'd9);
        chk("t2_r3", res_log[(base + 3) & 255], 128'd1);
        chk("t2_r4", res_log[(base + 4) & 255], 128'd0);

        // 3: back-pressure holds the product and blocks the next issue
        base      = done_n;
        fixed_rdy = 1'b0;
        tick();
        push(64'd7, 64'd6);
        push(64'd2, 64'd2);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            seen = out_valid;
        end
        chk("t3_valid_seen", 128'(seen), 128'd1);
        for (int i = 0; i < 10; i++) begin
            chk("t3_valid", 128'(out_valid), 128'd1);
            chk("t3_result", out_result, 128'd42);
            chk("t3_no_start", 128'(mul_op_start), 128'd0);
            chk("t3_queued", 128'(fifo_count), 128'd1);
            tick();
        end
        fixed_rdy = 1'b1;
        wait_results(base + 2, 100);
        chk("t3_second", res_log[(base + 1) & 255], 128'd4);

        // 4: reset in ISSUE with two pairs queued
        stall = 1'b1;
        push(64'd1, 64'd1);
        push(64'd2, 64'd2);
        push(64'd3, 64'd3);
        chk("t4_queued", 128'(fifo_count), 128'd2);
        chk("t4_in_issue", 128'(mul_op_start), 128'd1);
        reset = 1'b1;
        #1;
        chk("t4_start", 128'(mul_op_start), 128'd0);
        chk("t4_clear", 128'(mul_op_clear), 128'd0);
        chk("t4_valid", 128'(out_valid), 128'd0);
        chk("t4_count", 128'(fifo_count), 128'd0);
        chk("t4_in_ready", 128'(in_ready), 128'd0);
        chk("t4_mcand", 128'(mul_multiplicand), 128'd0);
        chk("t4_mplier", 128'(mul_multiplier), 128'd0);
        chk("t4_result", out_result, 128'd0);
        chk("t4_error", 128'(out_error), 128'd0);
        repeat (2) tick();
        stall = 1'b0;
        reset = 1'b0;
        base  = done_n;
        push(64'd2, 64'd3);
        wait_results(base + 1, 100);
        chk("t4_after_reset", last_res, 128'd6);

`ifdef MUL_TIMEOUT_EN
        // 5: watchdog
        base  = done_n;
        c0    = clears;
        stall = 1'b1;
        push(64'd4, 64'd4);
        wait_results(base + 1, 200);
        stall = 1'b0;
        repeat (2) tick();
        chk("t5_result", last_res, 128'd0);
        chk("t5_error", 128'(last_err), 128'd1);
        chk("t5_clear", 128'(clears - c0), 128'd1);
`endif

        // 6: spurious done while idle, then max operands
        repeat (3) tick();
        base     = done_n;
        spur_req = 1'b1;
        repeat (2) tick();
        spur_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t6_idle_valid", 128'(out_valid), 128'd0);
            chk("t6_idle_start", 128'(mul_op_start), 128'd0);
            chk("t6_idle_count", 128'(fifo_count), 128'd0);
            tick();
        end
        chk("t6_no_result", 128'(done_n), 128'(base));
        push(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);
        wait_results(base + 1, 100);
        chk("t6_max_square", last_res, 128'h3FFF_FFFF_FFFF_FFFF_0000_0000_0000_0001);

        // Randomized traffic
        base     = done_n;
        rand_rdy = 1'b1;
        for (int i = 0; i < 50; i++) begin
            push(pick(), pick());
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_results(base + 50, 3000);
        rand_rdy = 1'b0;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
